// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the 9-bit-instruction accumulator core.
// Steps each instruction through FETCH, EXEC and an optional MEM phase with a memory timeout.
module ctrl_sequencer #(
    parameter int DW      = 8,
    parameter int OPW     = 4,
    parameter int MEM_TMO = 15
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [8:0]     instr,
    input  logic           instr_valid,
    input  logic [DW-1:0]  datA,
    input  logic [DW-1:0]  datB,
    input  logic [DW-1:0]  alu_rslt,
    input  logic [DW-1:0]  lut_addr,
    input  logic [DW-1:0]  mem_rdata,
    input  logic           mem_ack,
    output logic           fetch_req,
    output logic           pc_en,
    output logic           branch,
    output logic [3:0]     pc_immed,
    output logic [3:0]     regA,
    output logic [3:0]     regB,
    output logic [3:0]     wr_addr,
    output logic           wr_en,
    output logic [DW-1:0]  wr_data,
    output logic [OPW-1:0] alu_op,
    output logic           alu_src,
    output logic [4:0]     immed,
    output logic [4:0]     lut_idx,
    output logic           mem_req,
    output logic           mem_we,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    output logic           busy,
    output logic           done,
    output logic           err
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_t;

    state_t         state, state_next;
    logic [8:0]     ir;
    logic [7:0]     tmo_cnt;
    logic           done_r, err_r;

    logic [2:0]     opcode;
    logic [1:0]     funct;
    logic [3:0]     field;

    logic [3:0]     dec_regA, dec_regB, dec_wr_addr;
    logic [OPW-1:0] dec_alu_op;
    logic           dec_alu_src;
    logic [DW-1:0]  dec_wr_data;
    logic [DW-1:0]  dec_addr;
    logic           dec_write, dec_load, dec_store, dec_exit, dec_taken;
    logic           tmo_hit;

    assign opcode   = ir[8:6];
    assign funct    = ir[5:4];
    assign field    = ir[3:0];
    assign pc_immed = ir[3:0];
    assign immed    = ir[5:1];
    assign lut_idx  = ir[5:1];
    assign busy     = (state == FETCH) || (state == EXEC) || (state == MEM);
    assign done     = done_r;
    assign err      = err_r;
    assign tmo_hit  = (tmo_cnt == 8'(MEM_TMO - 1)) && !mem_ack;

    // Instruction decode; held stable through MEM because it depends only on IR.
    always_comb begin
        dec_regA    = 4'd0;
        dec_regB    = 4'd1;
        dec_wr_addr = field;
        dec_alu_op  = '1;
        dec_alu_src = 1'b0;
        dec_wr_data = alu_rslt;
        dec_addr    = datA;
        dec_write   = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_exit    = 1'b0;
        dec_taken   = 1'b0;
        case (opcode)
            3'b000: begin
                case (funct)
                    2'b00: begin dec_alu_op = OPW'(0); dec_write = 1'b1; end
                    2'b01: begin dec_alu_op = OPW'(1); dec_write = 1'b1; end
                    2'b10: dec_load = 1'b1;
                    default: begin dec_store = 1'b1; dec_regB = field; end
                endcase
            end
            3'b001: begin
                dec_load    = 1'b1;
                dec_addr    = lut_addr;
                dec_wr_addr = {3'b000, ir[0]};
            end
            3'b010, 3'b011: begin
                dec_alu_op  = (opcode == 3'b010) ? OPW'(1) : OPW'(0);
                dec_alu_src = 1'b1;
                dec_wr_addr = 4'd1;
                dec_write   = 1'b1;
            end
            3'b100: begin
                case (funct)
                    2'b00:   dec_taken = (datA == datB);
                    2'b01:   dec_taken = (datA != datB);
                    2'b10:   dec_taken = (datA <  datB);
                    default: dec_taken = (datA <= datB);
                endcase
            end
            3'b101: begin
                dec_wr_data = datA;
                dec_write   = 1'b1;
                if (ir[5]) begin
                    dec_regA    = {3'b000, ir[0]};
                    dec_wr_addr = ir[4:1];
                end else begin
                    dec_regA    = field;
                    dec_wr_addr = {3'b000, ir[4]};
                end
            end
            3'b110: begin
                dec_alu_op = OPW'(funct) + OPW'(2);
                dec_write  = 1'b1;
            end
            default: begin
                if (funct == 2'b11) begin
                    dec_exit = 1'b1;
                end else begin
                    dec_alu_op = OPW'(funct) + OPW'(6);
                    dec_write  = 1'b1;
                end
            end
        endcase
    end

    // Next-state and strobe generation; decode outputs are only exposed in EXEC and MEM.
    always_comb begin
        state_next = state;
        fetch_req  = 1'b0;
        pc_en      = 1'b0;
        branch     = 1'b0;
        wr_en      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        regA       = 4'd0;
        regB       = 4'd0;
        wr_addr    = 4'd0;
        alu_op     = '0;
        alu_src    = 1'b0;
        wr_data    = '0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (instr_valid) state_next = EXEC;
            end
            EXEC: begin
                regA    = dec_regA;
                regB    = dec_regB;
                wr_addr = dec_wr_addr;
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                wr_data = dec_wr_data;
                mem_we  = dec_store;
                if (dec_load || dec_store) begin
                    state_next = MEM;
                end else if (dec_exit) begin
                    state_next = HALT;
                end else begin
                    wr_en      = dec_write;
                    pc_en      = 1'b1;
                    branch     = dec_taken;
                    state_next = FETCH;
                end
            end
            MEM: begin
                regA    = dec_regA;
                regB    = dec_regB;
                wr_addr = dec_wr_addr;
                alu_op  = dec_alu_op;
                alu_src = dec_alu_src;
                wr_data = dec_load ? mem_rdata : dec_wr_data;
                mem_req = 1'b1;
                mem_we  = dec_store;
                if (mem_ack) begin
                    wr_en      = dec_load;
                    pc_en      = 1'b1;
                    state_next = FETCH;
                end else if (tmo_hit) begin
                    state_next = HALT;
                end
            end
            HALT: begin
                if (start) state_next = FETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ir        <= '0;
            tmo_cnt   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state <= state_next;
            if (state == FETCH && instr_valid) ir <= instr;
            if (state == EXEC) begin
                tmo_cnt <= '0;
                if (dec_load || dec_store) mem_addr <= dec_addr;
                if (dec_store) mem_wdata <= datB;
                if (dec_exit) done_r <= 1'b1;
            end else if (state == MEM && !mem_ack) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                if (tmo_hit) err_r <= 1'b1;
            end else if (state == HALT && start) begin
                done_r <= 1'b0;
                err_r  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed self-checking bench for ctrl_sequencer with hand-computed expectations.
module tb_ctrl_sequencer;

    localparam int DW  = 8;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    logic [8:0]     instr;
    logic           instr_valid;
    logic [DW-1:0]  datA, datB, alu_rslt, lut_addr, mem_rdata;
    logic           mem_ack;
    logic           fetch_req, pc_en, branch, wr_en, alu_src, mem_req, mem_we;
    logic           busy, done, err;
    logic [3:0]     pc_immed, regA, regB, wr_addr;
    logic [DW-1:0]  wr_data, mem_addr, mem_wdata;
    logic [OPW-1:0] alu_op;
    logic [4:0]     immed, lut_idx;

    int checks   = 0;
    int failures = 0;

    localparam logic [8:0] I_ADDI3 = 9'b011_00011_0;
    localparam logic [8:0] I_LOAD3 = 9'b000_10_0011;
    localparam logic [8:0] I_ST2   = 9'b000_11_0010;
    localparam logic [8:0] I_BLT5  = 9'b100_10_0101;
    localparam logic [8:0] I_MOVH  = 9'b101_11_0101;
    localparam logic [8:0] I_ASR   = 9'b110_01_0100;
    localparam logic [8:0] I_RXOR  = 9'b111_10_0111;
    localparam logic [8:0] I_EXIT  = 9'b111_11_0000;

    ctrl_sequencer #(.DW(DW), .OPW(OPW), .MEM_TMO(15)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .instr(instr),
        .instr_valid(instr_valid), .datA(datA), .datB(datB), .alu_rslt(alu_rslt),
        .lut_addr(lut_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .fetch_req(fetch_req), .pc_en(pc_en), .branch(branch), .pc_immed(pc_immed),
        .regA(regA), .regB(regB), .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data),
        .alu_op(alu_op), .alu_src(alu_src), .immed(immed), .lut_idx(lut_idx),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction from FETCH and leaves the bench in its EXEC cycle.
    task automatic issue(input logic [8:0] word);
        instr       = word;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; instr = '0; instr_valid = 1'b0;
        datA = '0; datB = '0; alu_rslt = '0; lut_addr = '0; mem_rdata = '0; mem_ack = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_fetch_req", fetch_req, 0);
        chk("rst_regB", regB, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_done_err", {done, err}, 0);
        tick(); tick();
        reset_n = 1'b1;
        #1;
        chk("idle_no_start", busy, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("fetch_req", fetch_req, 1);
        chk("fetch_busy", busy, 1);

        // addi #3
        issue(I_ADDI3);
        datA = 8'd5; alu_rslt = 8'd8;
        #1;
        chk("addi_alu_src", alu_src, 1);
        chk("addi_alu_op", alu_op, 0);
        chk("addi_wr_addr", wr_addr, 1);
        chk("addi_wr_en", wr_en, 1);
        chk("addi_wr_data", wr_data, 8'd8);
        chk("addi_pc_en", pc_en, 1);
        chk("addi_immed", immed, 5'd3);
        tick();
        chk("addi_back_fetch", {fetch_req, wr_en, pc_en}, 3'b100);

        // load with three wait cycles
        issue(I_LOAD3);
        datA = 8'h40;
        #1;
        chk("ld_exec_strobes", {wr_en, pc_en, mem_req}, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            datA = 8'h00;
            if (i == 3) begin
                mem_ack = 1'b1; mem_rdata = 8'hA5;
            end
            #1;
            chk("ld_mem_req", mem_req, 1);
            chk("ld_mem_addr", mem_addr, 8'h40);
            chk("ld_wr_en", wr_en, (i == 3) ? 1 : 0);
        end
        chk("ld_wr_data", wr_data, 8'hA5);
        chk("ld_wr_addr", wr_addr, 3);
        chk("ld_pc_en", pc_en, 1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("ld_after", {fetch_req, mem_req, wr_en}, 3'b100);

        // store field 2 with immediate ack
        issue(I_ST2);
        datA = 8'h10; datB = 8'h77;
        #1;
        chk("st_regB", regB, 2);
        chk("st_exec_we", {mem_we, wr_en, mem_req}, 3'b100);
        tick();
        datB = 8'h00; mem_ack = 1'b1;
        #1;
        chk("st_mem_strobes", {mem_req, mem_we, wr_en, pc_en}, 4'b1101);
        chk("st_mem_wdata", mem_wdata, 8'h77);
        chk("st_mem_addr", mem_addr, 8'h10);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("st_after", {fetch_req, mem_we, wr_en}, 3'b100);

        // blt taken then not taken
        issue(I_BLT5);
        datA = 8'd3; datB = 8'd9;
        #1;
        chk("blt_taken", {branch, pc_en, wr_en}, 3'b110);
        chk("blt_pc_immed", pc_immed, 5);
        tick();
        issue(I_BLT5);
        datA = 8'd9;
        #1;
        chk("blt_not_taken", {branch, pc_en}, 2'b01);
        tick();

        // move (IR[5]=1), asr, rxor
        issue(I_MOVH);
        datA = 8'h5C;
        #1;
        chk("mov_regA", regA, 1);
        chk("mov_wr_addr", wr_addr, 4'hA);
        chk("mov_wr_data", wr_data, 8'h5C);
        tick();
        issue(I_ASR);
        #1;
        chk("asr_alu_op", alu_op, 3);
        tick();
        issue(I_RXOR);
        #1;
        chk("rxor_alu_op", alu_op, 8);
        chk("rxor_wr_addr", wr_addr, 7);
        tick();

        // load timing out after 15 MEM cycles
        issue(I_LOAD3);
        datA = 8'h22;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("tmo_mem_req", {mem_req, err, wr_en}, 3'b100);
        end
        tick();
        chk("tmo_err", err, 1);
        chk("tmo_halt", {busy, mem_req, wr_en, pc_en, done}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("tmo_restart", {err, fetch_req, busy}, 3'b011);

        // load acked on the 15th MEM cycle: ack wins
        issue(I_LOAD3);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 14) begin
                mem_ack = 1'b1; mem_rdata = 8'h3C;
            end
            #1;
            chk("ack15_mem_req", mem_req, 1);
        end
        chk("ack15_wr", {wr_en, pc_en}, 2'b11);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("ack15_no_err", {err, fetch_req}, 2'b01);

        // exit
        issue(I_EXIT);
        #1;
        chk("exit_exec", {pc_en, wr_en, done}, 0);
        tick();
        chk("exit_done", {done, busy}, 2'b10);

        // reset mid-MEM
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("exit_restart", {done, fetch_req}, 2'b01);
        issue(I_LOAD3);
        datA = 8'h66;
        tick();
        chk("pre_rst_mem_req", mem_req, 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_mem", {mem_req, busy, wr_en, pc_en}, 0);
        chk("rst_mid_mem_addr", mem_addr, 0);
        chk("rst_mid_regB", regB, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_idle", {busy, fetch_req, done, err}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Multi-cycle control unit for the 9-bit-instruction accumulator/register core. It replaces the single-cycle combinational decoder. It sequences each instruction through fetch, execute and an optional memory phase, with a req/ack handshake to instruction and data memory. Data width is parametrised, and a memory-timeout error is reported. It sits between the instruction ROM/PC, the register file, the ALU and data memory, and drives all their control inputs.

## Interface
- DW, 8: datapath width (register, ALU, memory data and address)
- OPW, 4: ALU opcode width
- MEM_TMO, 15: max cycles in MEM without mem_ack before error (1..255)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  begin/resume execution (honoured in IDLE and HALT only)
- instr  in  9  instruction word from ROM
- instr_valid  in  1  instr valid this cycle
- datA, datB  in  DW  register-file read data for regA/regB
- alu_rslt  in  DW  ALU result
- lut_addr  in  DW  address from load LUT indexed by lut_idx
- mem_rdata  in  DW  data-memory read data
- mem_ack  in  1  data-memory access complete
- fetch_req  out  1  request instruction at current PC
- pc_en, branch  out  1  advance PC / take relative branch by pc_immed
- pc_immed  out  4  branch offset, IR[3:0]
- regA, regB, wr_addr  out  4  register addresses
- wr_en  out  1  register write strobe
- wr_data  out  DW  register write data
- alu_op  out  OPW; alu_src  out  1 (1 = immediate); immed  out  5 (IR[5:1])
- lut_idx  out  5  IR[5:1]
- mem_req, mem_we  out  1  data-memory request / write
- mem_addr, mem_wdata  out  DW  registered address and write data
- busy, done, err  out  1  executing / halted by exit / halted by timeout

## Operation
- State register: IDLE, FETCH, EXEC, MEM, HALT. A 9-bit IR and a timeout counter are also registered.
- IDLE: on start go to FETCH.
- FETCH: assert fetch_req. On instr_valid, load IR and go to EXEC. Otherwise stay (no timeout).
- EXEC: decode IR as follows. opcode = IR[8:6], funct = IR[5:4], field = IR[3:0].
  - Defaults: regA = 0, regB = 1, wr_addr = field, alu_op = all-ones, wr_data = alu_rslt.
  - 000 funct 00 add (alu_op 0), 01 sub (alu_op 1): write field.
  - 000 funct 10 load: capture mem_addr = datA, then go to MEM.
  - 000 funct 11 store: regB = field; capture mem_addr = datA and mem_wdata = datB; mem_we = 1; then go to MEM.
  - 001 lb: capture mem_addr = lut_addr; wr_addr = {000, IR[0]}; then go to MEM.
  - 010 subi (alu_op 1), 011 addi (alu_op 0): alu_src = 1, wr_addr = 1.
  - 100 branch, unsigned compare of datA vs datB: funct 00 eq, 01 ne, 10 lt, 11 le. branch = condition; no write.
  - 101 move: if IR[5] = 0, regA = field and wr_addr = {000, IR[4]}. If IR[5] = 1, regA = {000, IR[0]} and wr_addr = IR[4:1]. wr_data = datA.
  - 110 funct 00..11 → alu_op 2..5 (lsl, asr, lsr, not).
  - 111 funct 00..10 → alu_op 6..8 (and, xor, rxor).
  - 111 funct 11 exit: no write; go to HALT and set done.
- Non-memory, non-exit instructions: wr_en (if writing) and pc_en pulse for the single EXEC cycle, then go to FETCH.
- MEM: hold mem_req = 1 and keep mem_addr, mem_wdata and mem_we stable. Register addresses hold the EXEC decode.
  - On mem_ack: for a load, wr_en = 1 and wr_data = mem_rdata. pc_en = 1. Go to FETCH.
  - Timeout counter clears on MEM entry and increments each MEM cycle without ack. When it reaches MEM_TMO, set err and go to HALT with no write and no pc_en.
  - mem_ack in the same cycle as expiry: ack wins, no error.
- HALT: done (or err) is held. start clears done and err and goes to FETCH at the current PC.
- busy = 1 in FETCH, EXEC and MEM.
- Outside EXEC and MEM, all strobes (wr_en, pc_en, branch, mem_req, mem_we) are 0.

## Timing
- Reset (asynchronous, immediate): state IDLE; IR, mem_addr, mem_wdata and the timeout counter are 0. All outputs are 0, including mem_req, which drops mid-access.
- Register/ALU/branch/move instructions: 2 cycles (FETCH, EXEC), with zero ROM wait.
- Load/store: 3 + w cycles, where w = MEM cycles before mem_ack. Ack in the first MEM cycle gives w = 0.
- Decode outputs are combinational from IR and state. mem_addr and mem_wdata are registered on the EXEC→MEM edge.
- wr_en, pc_en and branch are single-cycle pulses, sampled on the clock edge ending EXEC (or ending the acked MEM cycle).
- done rises the cycle after the exit EXEC. err rises the cycle after the MEM cycle in which the counter reaches MEM_TMO.
- start while busy is ignored.

## Test plan
- addi #3 (IR=0_11_00011_x), datA=5, alu_rslt=8 → EXEC: alu_src=1, alu_op=0, wr_addr=1, wr_en=1, wr_data=8, pc_en=1; back in FETCH next cycle.
- load, datA=0x40, mem_ack after 3 wait cycles, mem_rdata=0xA5 → mem_req held 4 cycles, mem_addr=0x40, wr_en=1 with 0xA5 on the ack cycle only.
- store to field 2, datA=0x10, datB=0x77, immediate ack → mem_we=1, mem_wdata=0x77, wr_en never set.
- blt with datA=3, datB=9 → branch=1, pc_immed=IR[3:0]. With datA=9 → branch=0, pc_en=1.
- load with no ack → err=1 after MEM_TMO=15 cycles, state HALT, no wr_en. start then gives err=0 and FETCH. A repeat run with ack on cycle 15 gives no err.
- exit gives done=1 and busy=0. reset_n low mid-MEM drops mem_req in the same cycle and returns to IDLE with all outputs 0.
